r3_shadow_checker: RTL and testbench

// - Per-core simulation/monitor helper: rebuilds the value of a CPU GPR from the core's retire trace (mor1kx trace_exec).
// - Keeps a shadow register file fed by trace writeback events and exposes the tracked register (r3 by default).
// - One instance per core sits beside the trace monitor, which decodes l.nop K-codes (exit, putc, report) using the r3 argument.

---
 rtl/r3_shadow_checker_pkg.sv | 16 +
 rtl/r3_shadow_checker.sv | 61 ++++++
 tb/tb_r3_shadow_checker.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/r3_shadow_checker_pkg.sv
// Shared helpers for the per-core shadow register file that rebuilds GPR state from the retire trace.
package r3_shadow_checker_pkg;

  // A trace entry only changes shadow state when it retires, writes back, is outside reset,
  // and does not target the hard-wired zero register.
  function automatic logic shadowWriteEvent(
    input logic valid,
    input logic we,
    input logic rst,
    input logic addrIsR0,
    input bit   ignoreR0
  );
    return valid & we & ~rst & ~(ignoreR0 & addrIsR0);
  endfunction

endpackage

// File: rtl/r3_shadow_checker.sv
// Shadow GPR file fed by mor1kx trace writebacks; exposes the tracked register (r3 by default)
// with and without a same-cycle bypass, plus a debug read port.
module r3_shadow_checker
  import r3_shadow_checker_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int TRACK_REG  = 3,
  parameter bit IGNORE_R0  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid,
  input  logic                        we,
  input  logic [$clog2(NUM_REGS)-1:0] addr,
  input  logic [DATA_WIDTH-1:0]       data,
  output logic [DATA_WIDTH-1:0]       r3,
  output logic [DATA_WIDTH-1:0]       r3_q,
  output logic                        r3_written,
  input  logic [$clog2(NUM_REGS)-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]       rd_data
);

  localparam int              AW        = $clog2(NUM_REGS);
  localparam logic [AW-1:0]   TRACK_IDX = AW'(TRACK_REG);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic                  r_written;

  logic w_addrIsR0;
  logic w_rdIsR0;
  logic w_writeEvent;
  logic w_trackHit;

  assign w_addrIsR0   = (addr == '0);
  assign w_rdIsR0     = (rd_addr == '0);
  assign w_writeEvent = shadowWriteEvent(valid, we, rst, w_addrIsR0, IGNORE_R0);
  assign w_trackHit   = w_writeEvent && (addr == TRACK_IDX);

  // Flop array rather than RAM: every read below is combinational.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_written <= 1'b0;
    end else if (w_writeEvent) begin
      r_regs[addr] <= data;
      if (addr == TRACK_IDX) begin
        r_written <= 1'b1;
      end
    end
  end

  // Outputs are forced to zero during reset so the monitor never sees pre-reset contents.
  assign r3         = rst ? '0 : (w_trackHit ? data : r_regs[TRACK_REG]);
  assign r3_q       = rst ? '0 : r_regs[TRACK_REG];
  assign r3_written = r_written;
  assign rd_data    = (rst || (IGNORE_R0 && w_rdIsR0)) ? '0 : r_regs[rd_addr];

endmodule

// File: tb/tb_r3_shadow_checker.sv
// Self-checking bench for r3_shadow_checker: directed trace steps then a random stream against a reference array.
module tb_r3_shadow_checker;

  typedef struct packed {
    logic [31:0] r3;
    logic [31:0] r3q;
    logic [31:0] rd;
    logic        wr;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        valid;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] data;
  logic [31:0] r3;
  logic [31:0] r3_q;
  logic        r3_written;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;

  int errors;
  int checks;

  logic [31:0] mRegs [32];
  logic        mWritten;
  exp_t        sb [$];

  r3_shadow_checker dut (
    .clk        (clk),
    .rst        (rst),
    .valid      (valid),
    .we         (we),
    .addr       (addr),
    .data       (data),
    .r3         (r3),
    .r3_q       (r3_q),
    .r3_written (r3_written),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one trace entry just after the rising edge and push the model's prediction for that cycle.
  task automatic applyStimulus(input logic r, input logic v, input logic w,
                               input logic [4:0] a, input logic [31:0] d, input logic [4:0] ra);
    exp_t e;
    logic ev;
    @(posedge clk);
    #1;
    rst = r; valid = v; we = w; addr = a; data = d; rd_addr = ra;
    ev = !r && v && w && (a != 5'd0);
    e.r3  = r ? 32'h0 : ((ev && a == 5'd3) ? d : mRegs[3]);
    e.r3q = r ? 32'h0 : mRegs[3];
    e.rd  = (r || ra == 5'd0) ? 32'h0 : mRegs[ra];
    e.wr  = mWritten;
    sb.push_back(e);
  endtask

  // Compare mid-cycle against the queued prediction, then advance the model across the coming edge.
  task automatic checkOutput(input string tag);
    exp_t e;
    @(negedge clk);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty: observed none required one entry", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (r3 === e.r3) else begin
        errors++; $error("[TB] FAIL %s r3 observed=%h expected=%h", tag, r3, e.r3);
      end
      checks++;
      assert (r3_q === e.r3q) else begin
        errors++; $error("[TB] FAIL %s r3_q observed=%h expected=%h", tag, r3_q, e.r3q);
      end
      checks++;
      assert (rd_data === e.rd) else begin
        errors++; $error("[TB] FAIL %s rd_data[%0d] observed=%h expected=%h", tag, rd_addr, rd_data, e.rd);
      end
      checks++;
      assert (r3_written === e.wr) else begin
        errors++; $error("[TB] FAIL %s r3_written observed=%b expected=%b", tag, r3_written, e.wr);
      end
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
      mWritten = 1'b0;
    end else if (valid && we && addr != 5'd0) begin
      mRegs[addr] = data;
      if (addr == 5'd3) mWritten = 1'b1;
    end
  endtask

  task automatic step(input string tag, input logic r, input logic v, input logic w,
                      input logic [4:0] a, input logic [31:0] d, input logic [4:0] ra);
    applyStimulus(r, v, w, a, d, ra);
    checkOutput(tag);
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; valid = 1'b0; we = 1'b0; addr = '0; data = '0; rd_addr = '0;
    for (int i = 0; i < 32; i++) mRegs[i] = 32'h0;
    mWritten = 1'b0;
    repeat (2) @(posedge clk);

    // Reset held, then first write to r3 with bypass and delayed stored copy
    for (int i = 0; i < 3; i++) step("reset", 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3);
    step("first_write",  1'b0, 1'b1, 1'b1, 5'd3, 32'h0000_0041, 5'd3);
    step("after_first",  1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3);

    // Inactive entries must not change state
    step("valid_low",    1'b0, 1'b0, 1'b1, 5'd3, 32'h0000_0011, 5'd3);
    step("we_low",       1'b0, 1'b1, 1'b0, 5'd3, 32'h0000_0022, 5'd3);
    step("after_inact",  1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3);

    // r0 is hard-wired; a high register is visible on the debug port a cycle later
    step("r0_write",     1'b0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF, 5'd0);
    step("r0_read",      1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0);
    step("r31_write",    1'b0, 1'b1, 1'b1, 5'd31, 32'h0000_1234, 5'd31);
    step("r31_read",     1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd31);

    // Back-to-back writes to r3
    step("b2b_1",        1'b0, 1'b1, 1'b1, 5'd3, 32'h1, 5'd3);
    step("b2b_2",        1'b0, 1'b1, 1'b1, 5'd3, 32'h2, 5'd3);
    step("b2b_3",        1'b0, 1'b1, 1'b1, 5'd3, 32'h3, 5'd3);
    step("b2b_final",    1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3);

    // Reset wins over a simultaneous write
    step("pre_rst_wr",   1'b0, 1'b1, 1'b1, 5'd3, 32'h55, 5'd3);
    step("pre_rst_idle", 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3);
    step("rst_with_wr",  1'b1, 1'b1, 1'b1, 5'd3, 32'h66, 5'd3);
    step("post_rst",     1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3);
    step("post_rst_31",  1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd31);

    // Random trace stream with occasional mid-run resets
    for (int n = 0; n < 10000; n++) begin
      step("random",
           ($urandom_range(0, 499) == 0),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 5'd3 : 5'($urandom_range(0, 31)),
           $urandom,
           5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
